// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_value(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    // Saturation pattern: 4'h9 in each of the low 'digits' nibbles.
    function automatic logic [19:0] all_nines(input int unsigned digits);
        logic [19:0] v;
        v = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            v[4*i +: 4] = 4'h9;
        end
        return v;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Single-nibble double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] nib,
    output logic [3:0] adj_c
);

    assign adj_c = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional macro BIN_TO_BCD_AUTO_EN: self-start whenever bin_in changes while idle.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned SR_W    = BCD_W + IN_W;
    localparam int unsigned CNT_W   = $clog2(IN_W + 1);
    localparam int unsigned MAX_VAL = max_value(DIGITS);
    localparam logic [BCD_W-1:0] NINES = BCD_W'(all_nines(DIGITS));

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_next;
    logic              accept;
    logic              bin_ovf;

    assign bin_ovf = 32'(bin_in) > MAX_VAL;

`ifdef BIN_TO_BCD_AUTO_EN
    logic [IN_W-1:0] last_bin;

    assign accept = start || (bin_in != last_bin);
`else
    assign accept = start;
`endif

    // Per-digit correction ahead of each shift; the binary field passes through.
    assign sr_adj[IN_W-1:0] = sr[IN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib   (sr[IN_W + 4*g +: 4]),
            .adj_c (sr_adj[IN_W + 4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
`ifdef BIN_TO_BCD_AUTO_EN
            last_bin <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sr       <= {{BCD_W{1'b0}}, bin_in};
                        cnt      <= CNT_W'(IN_W);
                        ovf_next <= bin_ovf;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
`ifdef BIN_TO_BCD_AUTO_EN
                        last_bin <= bin_in;
`endif
                    end
                end
                ST_SHIFT: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_out <= ovf_next ? NINES : sr[SR_W-1:IN_W];
                    ovf     <= ovf_next;
                    done    <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter feeding the seven-segment dynamic display stage. It takes the binary value the core publishes for display and converts it into packed decimal digits with the shift-add-3 (double-dabble) algorithm, one bit per cycle. A start/busy/done handshake lets the display stage latch a stable result. It runs on the same divided system clock as the core and display.

## Interface
Parameters:
- IN_W, default 14: binary input width, 4..16.
- DIGITS, default 4: decimal digits produced, 1..5; the display uses 4.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- bin_in  input  IN_W  binary value; captured on the cycle start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/ovf update.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0], most significant digit at top.
- ovf  output  1  last captured value exceeded 10^DIGITS-1.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encode as a 2-bit enum.
- IDLE: on start=1, capture bin_in into the low IN_W bits of a (4*DIGITS+IN_W)-bit shift register. Clear the BCD bits. Load the bit counter with IN_W. Compute ovf_next = (bin_in > 10^DIGITS-1). Go to SHIFT.
- SHIFT: each cycle, first add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1 and decrement the counter. When the counter reaches 1 on this cycle, go to DONE.
- DONE: load bcd_out with the BCD field, or all nines (4'h9 per digit) if ovf_next=1. Load ovf with ovf_next. Pulse done. Return to IDLE.
- Latency is constant and independent of the value; overflowing inputs still run all IN_W shifts.
- bin_in may change freely after capture; it is not sampled again until the next accept.
- start while in SHIFT or DONE is ignored, not queued.
- bcd_out and ovf hold their last result until the next DONE.
- Nibble correction arithmetic is 4-bit. Carries cannot occur because a corrected nibble is at most 12 before the shift.

## Timing
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, shift register=0, counter=0.
- If start is accepted on edge N, busy=1 from N+1 through N+IN_W, and done=1 for exactly the cycle after edge N+IN_W+1.
- busy=0 in the DONE cycle.
- With IN_W=14, done arrives 15 cycles after the accept edge.
- A new start can be accepted on the edge ending the DONE cycle's successor (IDLE). This gives a minimum start-to-start spacing of IN_W+2 cycles.
- rst asserted in any state returns every register to its reset value on that edge. An in-flight conversion is discarded and done is not pulsed.
- start and rst high together: rst wins.

## Configuration
- Macro BIN_TO_BCD_AUTO_EN.
- Defined: the block holds a last-accepted copy of bin_in. In IDLE it self-starts whenever bin_in differs from that copy, or when start=1. The copy updates on each accept and resets to 0. With this macro, the display refreshes without the core issuing start.
- Not defined: conversions begin only on start. The copy register and comparator are absent.

## Structure
- Shared package bin_to_bcd_pkg holds:
  - the state enum type;
  - a constant function returning 10^DIGITS-1 for the overflow bound;
  - the all-nines constant generator.
- One sub-module, bcd_digit_adj: a combinational single-nibble add-3-if->=5. Instantiate it DIGITS times with generate.

## Test plan
- Defaults, start with bin_in=1234 -> done exactly 15 cycles after accept; bcd_out=16'h1234, ovf=0; busy high for 14 cycles.
- bin_in=0, then bin_in=9999 back-to-back at minimum spacing -> bcd_out=16'h0000, then 16'h9999, both ovf=0.
- bin_in=12000 -> bcd_out=16'h9999, ovf=1; same latency as a valid input.
- Accept 4321, pulse start with 5555 at cycle 5 of SHIFT -> result 16'h4321; second start ignored; no second done.
- Accept 777, assert rst at cycle 7 of SHIFT -> all outputs 0 next cycle; no done; a subsequent start with 42 yields 16'h0042.
- With BIN_TO_BCD_AUTO_EN defined and start tied low: bin_in 0->256 -> one conversion, bcd_out=16'h0256. Holding 256 triggers no further done pulses.
